// File: rtl/auto_range_ctrl_pkg.sv
// Shared types and constants for the auto-ranging sequencer.
package auto_range_ctrl_pkg;

  typedef enum logic [1:0] {MEAS, EVAL, SWITCH, SETTLE} state_e;

  // Range index end points (gate select / reference select)
  localparam logic [1:0] F_1S  = 2'd0;
  localparam logic [1:0] F_1MS = 2'd3;
  localparam logic [1:0] T_10K = 2'd0;
  localparam logic [1:0] T_10M = 2'd3;

  localparam int HYST_DEF       = 2;
  localparam int RST_CYC_DEF    = 4;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int TIMEOUT_DEF    = 150_000_000;

  // Saturating +/-1 step on a 2-bit range index
  function automatic logic [1:0] sat_step(input logic [1:0] s, input logic inc);
    if (inc) return (s == 2'd3) ? s : s + 2'd1;
    else     return (s == 2'd0) ? s : s - 2'd1;
  endfunction

endpackage

// File: rtl/auto_range_ctrl_range_timer.sv
// Loadable down-counter; done is high while enabled and the count has hit zero.
module range_timer #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   INIT = '0
)(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     cnt_q <= INIT;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/auto_range_ctrl.sv
// Auto-ranging sequencer: steps gate/reference select on overflow or
// sustained under-range, then resets and settles the measurement chain.
module auto_range_ctrl
  import auto_range_ctrl_pkg::*;
#(
  parameter int HYST       = HYST_DEF,
  parameter int RST_CYC    = RST_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
)(
  input  logic       CLK_50,
  input  logic       nRST,
  input  logic       measure_mode,
  input  logic       auto_en,
  input  logic [1:0] man_sel,
  input  logic       C_Store,
  input  logic       OF,
  input  logic       under_rng,
  output logic [1:0] F_sel,
  output logic [1:0] T_sel,
  output logic       range_change,
  output logic       ini_nRST,
  output logic       busy,
  output logic       no_sig
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = $clog2(HYST + 1);

  state_e        state_q, state_d;
  logic [1:0]    f_sel_q, f_sel_d, t_sel_q, t_sel_d, cur_sel, new_sel;
  logic [HW-1:0] hyst_q, hyst_d;
  logic          no_sig_q, no_sig_d, of_q, of_d, ur_q, ur_d;
  logic          cstore_q, mode_q, rc_q, ini_q, busy_q;
  logic          evt, toggle, man_pend, enter_sw;
  logic          tmo_load, tmo_done, ph_load, ph_done;
  logic [TW-1:0] ph_val;

  assign evt      = C_Store & ~cstore_q;
  assign toggle   = measure_mode ^ mode_q;
  // Registered mode selects the active index so a toggle never splits a cycle
  assign cur_sel  = mode_q ? t_sel_q : f_sel_q;
  assign man_pend = ~auto_en && (man_sel != cur_sel);

  // Timeout counter: runs only in MEAS, held reloaded elsewhere
  range_timer #(.W(TW), .INIT(TW'(TIMEOUT - 1))) u_tmo (
    .clk_i(CLK_50), .rst_ni(nRST), .en_i(state_q == MEAS),
    .load_i(tmo_load), .load_val_i(TW'(TIMEOUT - 1)), .done_o(tmo_done));

  // Phase counter shared by SWITCH (reset hold) and SETTLE
  range_timer #(.W(TW), .INIT('0)) u_phase (
    .clk_i(CLK_50), .rst_ni(nRST), .en_i(state_q == SWITCH || state_q == SETTLE),
    .load_i(ph_load), .load_val_i(ph_val), .done_o(ph_done));

  // Next-state, range selection, hysteresis and timer control
  always_comb begin
    state_d  = state_q;
    f_sel_d  = f_sel_q;
    t_sel_d  = t_sel_q;
    hyst_d   = hyst_q;
    no_sig_d = no_sig_q;
    of_d     = of_q;
    ur_d     = ur_q;
    tmo_load = 1'b0;
    ph_load  = 1'b0;
    ph_val   = TW'(RST_CYC - 1);
    new_sel  = cur_sel;
    unique case (state_q)
      MEAS: begin
        if (evt) begin
          of_d = OF; ur_d = under_rng; no_sig_d = 1'b0; tmo_load = 1'b1;
        end else if (tmo_done) begin
          no_sig_d = 1'b1; tmo_load = 1'b1;
        end
        if (man_pend) begin
          new_sel = man_sel; state_d = SWITCH;
        end else if (evt) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        tmo_load = 1'b1;
        if (!auto_en) begin
          if (man_pend) begin new_sel = man_sel; state_d = SWITCH; end
          else          state_d = MEAS;
        end else begin
          // Less sensitive = F up / T down; more sensitive is the reverse
          if (of_q) begin
            new_sel = sat_step(cur_sel, ~mode_q);
            hyst_d  = '0;
          end else if (ur_q) begin
            if (hyst_q == HW'(HYST - 1)) begin
              new_sel = sat_step(cur_sel, mode_q);
              hyst_d  = '0;
            end else begin
              hyst_d  = hyst_q + HW'(1);
            end
          end else begin
            hyst_d = '0;
          end
          state_d = (new_sel != cur_sel) ? SWITCH : MEAS;
        end
      end
      SWITCH: begin
        tmo_load = 1'b1;
        if (ph_done) begin
          state_d = SETTLE; ph_load = 1'b1; ph_val = TW'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        tmo_load = 1'b1;
        if (ph_done) state_d = MEAS;
      end
      default: state_d = MEAS;
    endcase
    if (mode_q) t_sel_d = new_sel;
    else        f_sel_d = new_sel;
    if (!auto_en) hyst_d = '0;
    // Mode change restarts the switch sequence and discards any event this cycle
    if (toggle) begin
      state_d  = SWITCH;
      f_sel_d  = f_sel_q;
      t_sel_d  = t_sel_q;
      hyst_d   = '0;
      tmo_load = 1'b1;
      if (evt) no_sig_d = no_sig_q;
    end
    enter_sw = (state_d == SWITCH) && ((state_q != SWITCH) || toggle);
    if (enter_sw) begin
      ph_load = 1'b1; ph_val = TW'(RST_CYC - 1);
    end
  end

  // State and registered outputs (outputs track the next state, so they are glitch-free)
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state_q  <= MEAS;
      f_sel_q  <= F_1S;
      t_sel_q  <= T_10M;
      hyst_q   <= '0;
      no_sig_q <= 1'b0;
      of_q     <= 1'b0;
      ur_q     <= 1'b0;
      cstore_q <= 1'b0;
      mode_q   <= 1'b0;
      rc_q     <= 1'b0;
      ini_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_sel_q  <= f_sel_d;
      t_sel_q  <= t_sel_d;
      hyst_q   <= hyst_d;
      no_sig_q <= no_sig_d;
      of_q     <= of_d;
      ur_q     <= ur_d;
      cstore_q <= C_Store;
      mode_q   <= measure_mode;
      rc_q     <= enter_sw;
      ini_q    <= (state_d != SWITCH);
      busy_q   <= (state_d == SWITCH) || (state_d == SETTLE);
    end
  end

  assign F_sel        = f_sel_q;
  assign T_sel        = t_sel_q;
  assign range_change = rc_q;
  assign ini_nRST     = ini_q;
  assign busy         = busy_q;
  assign no_sig       = no_sig_q;

endmodule

// File: tb/tb_auto_range_ctrl.sv
// Bench for auto_range_ctrl: scenario tasks against a rule-level range model.
module tb_auto_range_ctrl;

  localparam int HYST = 2, RST_CYC = 4, SETTLE_CYC = 16, TIMEOUT = 100;

  logic       CLK_50 = 1'b0, nRST = 1'b0, measure_mode = 1'b0, auto_en = 1'b1;
  logic [1:0] man_sel = 2'd0;
  logic       C_Store = 1'b0, OF = 1'b0, under_rng = 1'b0;
  logic [1:0] F_sel, T_sel;
  logic       range_change, ini_nRST, busy, no_sig;

  auto_range_ctrl #(.HYST(HYST), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)) dut (
    .CLK_50(CLK_50), .nRST(nRST), .measure_mode(measure_mode), .auto_en(auto_en),
    .man_sel(man_sel), .C_Store(C_Store), .OF(OF), .under_rng(under_rng),
    .F_sel(F_sel), .T_sel(T_sel), .range_change(range_change), .ini_nRST(ini_nRST),
    .busy(busy), .no_sig(no_sig));

  always #10 CLK_50 = ~CLK_50;

  int n_pass = 0, n_chk = 0;
  // Reference model: range indices, hysteresis count and active mode
  int m_f = 0, m_t = 3, m_hyst = 0, m_mode = 0;
  // Observation results of the last window
  int rc_cnt, low_cnt, busy_cnt, rc_first, rc_last;
  logic [1:0] f_at2;
  logic       ns_at2;

  task automatic model_event(input bit of_b, input bit ur_b, output bit chg);
    int s, ns;
    s  = m_mode ? m_t : m_f;
    ns = s;
    if (of_b) begin
      ns = m_mode ? s - 1 : s + 1; m_hyst = 0;
    end else if (ur_b) begin
      m_hyst++;
      if (m_hyst == HYST) begin ns = m_mode ? s + 1 : s - 1; m_hyst = 0; end
    end else m_hyst = 0;
    if (ns < 0) ns = 0;
    if (ns > 3) ns = 3;
    chg = (ns != s);
    if (m_mode) m_t = ns; else m_f = ns;
  endtask

  // Watch n cycles (k = 1..n after the stimulus edge), with optional extra stimulus
  task automatic observe(input int n, input int tog_at, input int cs_at,
                         input int man_at, input logic [1:0] man_val);
    rc_cnt = 0; low_cnt = 0; busy_cnt = 0; rc_first = -1; rc_last = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK_50);
      if (range_change) begin rc_cnt++; if (rc_first < 0) rc_first = k; rc_last = k; end
      if (!ini_nRST) low_cnt++;
      if (busy) busy_cnt++;
      if (k == 2) begin f_at2 = F_sel; ns_at2 = no_sig; end
      C_Store = (k == cs_at);
      if (k == tog_at) measure_mode = ~measure_mode;
      if (k == man_at) man_sel = man_val;
    end
  endtask

  task automatic send_event(input bit of_b, input bit ur_b, input int n, input int cs_at);
    @(negedge CLK_50);
    C_Store = 1'b1; OF = of_b; under_rng = ur_b;
    observe(n, -1, cs_at, -1, 2'd0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK_50);
    n_chk++; if (F_sel !== 2'd0) $display("FAIL rst_fsel: got %0d exp 0", F_sel); else n_pass++;
    n_chk++; if (T_sel !== 2'd3) $display("FAIL rst_tsel: got %0d exp 3", T_sel); else n_pass++;
    n_chk++; if (range_change !== 1'b0) $display("FAIL rst_rc: got %b exp 0", range_change); else n_pass++;
    n_chk++; if (ini_nRST !== 1'b1) $display("FAIL rst_ini: got %b exp 1", ini_nRST); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (no_sig !== 1'b0) $display("FAIL rst_nosig: got %b exp 0", no_sig); else n_pass++;
    nRST = 1'b1;
    observe(5, -1, -1, -1, 2'd0);
    n_chk++; if (rc_cnt != 0 || busy_cnt != 0 || low_cnt != 0)
      $display("FAIL rst_idle: rc %0d busy %0d low %0d exp 0 0 0", rc_cnt, busy_cnt, low_cnt); else n_pass++;
  endtask

  task automatic test_of_step;
    bit chg;
    model_event(1'b1, 1'b0, chg);
    send_event(1'b1, 1'b0, 30, 10);   // second store edge lands in SETTLE
    n_chk++; if (f_at2 !== 2'(m_f)) $display("FAIL of_fsel_k2: got %0d exp %0d", f_at2, m_f); else n_pass++;
    n_chk++; if (rc_cnt != 1 || rc_first != 2) $display("FAIL of_rc: got %0d@%0d exp 1@2", rc_cnt, rc_first); else n_pass++;
    n_chk++; if (low_cnt != RST_CYC) $display("FAIL of_ini_low: got %0d exp %0d", low_cnt, RST_CYC); else n_pass++;
    n_chk++; if (busy_cnt != RST_CYC + SETTLE_CYC) $display("FAIL of_busy: got %0d exp %0d", busy_cnt, RST_CYC + SETTLE_CYC); else n_pass++;
    n_chk++; if (F_sel !== 2'd1) $display("FAIL of_settle_ignore: got %0d exp 1", F_sel); else n_pass++;
  endtask

  task automatic test_hyst;
    bit of_t[6] = '{1, 0, 0, 0, 0, 0};
    bit ur_t[6] = '{0, 1, 1, 1, 0, 1};
    bit chg;
    for (int i = 0; i < 6; i++) begin
      model_event(of_t[i], ur_t[i], chg);
      send_event(of_t[i], ur_t[i], 30, -1);
      n_chk++; if (rc_cnt != int'(chg) || F_sel !== 2'(m_f))
        $display("FAIL hyst_%0d: rc %0d F %0d exp rc %0d F %0d", i, rc_cnt, F_sel, chg, m_f); else n_pass++;
      if (i == 2) begin
        n_chk++; if (F_sel !== 2'd1) $display("FAIL hyst_second_under: got %0d exp 1", F_sel); else n_pass++;
      end
    end
  endtask

  task automatic test_manual;
    logic [1:0] tgt;
    man_sel = 2'(m_f);
    @(negedge CLK_50); auto_en = 1'b0;
    observe(5, -1, -1, -1, 2'd0);
    n_chk++; if (rc_cnt != 0) $display("FAIL man_same: rc %0d exp 0", rc_cnt); else n_pass++;
    tgt = (m_f == 2) ? 2'd0 : 2'd2;
    @(negedge CLK_50); man_sel = tgt;
    observe(50, -1, -1, 10, 2'd3);   // change again while settling
    m_f = 3; m_hyst = 0;
    n_chk++; if (rc_cnt != 2 || rc_first != 1) $display("FAIL man_rc: got %0d@%0d exp 2@1", rc_cnt, rc_first); else n_pass++;
    n_chk++; if (rc_last != 2 + RST_CYC + SETTLE_CYC) $display("FAIL man_pending_k: got %0d exp %0d", rc_last, 2 + RST_CYC + SETTLE_CYC); else n_pass++;
    n_chk++; if (low_cnt != 2 * RST_CYC) $display("FAIL man_ini_low: got %0d exp %0d", low_cnt, 2 * RST_CYC); else n_pass++;
    n_chk++; if (F_sel !== 2'(m_f)) $display("FAIL man_fsel: got %0d exp %0d", F_sel, m_f); else n_pass++;
    @(negedge CLK_50); auto_en = 1'b1;
    observe(5, -1, -1, -1, 2'd0);
    n_chk++; if (rc_cnt != 0) $display("FAIL man_to_auto: rc %0d exp 0", rc_cnt); else n_pass++;
  endtask

  task automatic test_timeout;
    bit chg;
    model_event(1'b0, 1'b0, chg);
    send_event(1'b0, 1'b0, 30, -1);
    repeat (40) @(negedge CLK_50);
    n_chk++; if (no_sig !== 1'b0) $display("FAIL tmo_early: got %b exp 0", no_sig); else n_pass++;
    repeat (50) @(negedge CLK_50);
    n_chk++; if (no_sig !== 1'b1) $display("FAIL tmo_set: got %b exp 1", no_sig); else n_pass++;
    model_event(1'b0, 1'b0, chg);
    send_event(1'b0, 1'b0, 30, -1);
    n_chk++; if (ns_at2 !== 1'b0) $display("FAIL tmo_clear: got %b exp 0", ns_at2); else n_pass++;
  endtask

  task automatic test_random(input int n);
    bit of_b, ur_b, chg;
    for (int i = 0; i < n; i++) begin
      of_b = ($urandom_range(0, 3) == 0);
      ur_b = $urandom_range(0, 1);
      model_event(of_b, ur_b, chg);
      send_event(of_b, ur_b, 30, -1);
      n_chk++; if (rc_cnt != int'(chg) || low_cnt != (chg ? RST_CYC : 0))
        $display("FAIL rnd_seq_%0d: rc %0d low %0d exp chg %0d", i, rc_cnt, low_cnt, chg); else n_pass++;
      n_chk++; if (F_sel !== 2'(m_f) || T_sel !== 2'(m_t))
        $display("FAIL rnd_sel_%0d: F %0d T %0d exp F %0d T %0d", i, F_sel, T_sel, m_f, m_t); else n_pass++;
    end
  endtask

  task automatic test_mode_toggle;
    @(negedge CLK_50); measure_mode = ~measure_mode;
    observe(30, 2, -1, -1, 2'd0);   // toggle back mid-SWITCH
    m_hyst = 0;
    n_chk++; if (rc_cnt != 2 || rc_last != 3) $display("FAIL tog_rc: got %0d last@%0d exp 2@3", rc_cnt, rc_last); else n_pass++;
    n_chk++; if (low_cnt != 2 + RST_CYC) $display("FAIL tog_ini_low: got %0d exp %0d", low_cnt, 2 + RST_CYC); else n_pass++;
    // Store edge and mode toggle together: event discarded
    @(negedge CLK_50); C_Store = 1'b1; OF = 1'b1; under_rng = 1'b0; measure_mode = ~measure_mode;
    observe(30, -1, -1, -1, 2'd0);
    m_mode = measure_mode; m_hyst = 0;
    n_chk++; if (rc_cnt != 1 || low_cnt != RST_CYC) $display("FAIL tog_evt: rc %0d low %0d exp 1 %0d", rc_cnt, low_cnt, RST_CYC); else n_pass++;
    n_chk++; if (F_sel !== 2'(m_f) || T_sel !== 2'(m_t))
      $display("FAIL tog_evt_sel: F %0d T %0d exp F %0d T %0d", F_sel, T_sel, m_f, m_t); else n_pass++;
  endtask

  task automatic test_saturation;
    bit chg;
    while (m_t != 0) begin
      model_event(1'b1, 1'b0, chg);
      send_event(1'b1, 1'b0, 30, -1);
      n_chk++; if (T_sel !== 2'(m_t) || rc_cnt != 1) $display("FAIL sat_walk: T %0d rc %0d exp T %0d rc 1", T_sel, rc_cnt, m_t); else n_pass++;
    end
    model_event(1'b1, 1'b0, chg);
    send_event(1'b1, 1'b0, 30, -1);
    n_chk++; if (T_sel !== 2'd0) $display("FAIL sat_tsel: got %0d exp 0", T_sel); else n_pass++;
    n_chk++; if (rc_cnt != 0 || low_cnt != 0) $display("FAIL sat_noswitch: rc %0d low %0d exp 0 0", rc_cnt, low_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_switch;
    @(negedge CLK_50); measure_mode = ~measure_mode;
    repeat (2) @(negedge CLK_50);
    n_chk++; if (ini_nRST !== 1'b0) $display("FAIL mid_in_switch: ini %b exp 0", ini_nRST); else n_pass++;
    nRST = 1'b0; measure_mode = 1'b0;
    #1;
    n_chk++; if (F_sel !== 2'd0 || T_sel !== 2'd3) $display("FAIL mid_rst_sel: F %0d T %0d exp 0 3", F_sel, T_sel); else n_pass++;
    n_chk++; if (ini_nRST !== 1'b1 || range_change !== 1'b0 || busy !== 1'b0 || no_sig !== 1'b0)
      $display("FAIL mid_rst_ctl: ini %b rc %b busy %b nosig %b exp 1 0 0 0", ini_nRST, range_change, busy, no_sig); else n_pass++;
    m_f = 0; m_t = 3; m_hyst = 0; m_mode = 0;
    @(negedge CLK_50); nRST = 1'b1;
    observe(5, -1, -1, -1, 2'd0);
    n_chk++; if (busy_cnt != 0 || rc_cnt != 0) $display("FAIL mid_release: busy %0d rc %0d exp 0 0", busy_cnt, rc_cnt); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_of_step;
    test_hyst;
    test_manual;
    test_timeout;
    test_random(24);
    test_mode_toggle;
    test_saturation;
    test_random(24);
    test_reset_mid_switch;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

endmodule
